// File: rtl/rf_wb_sched.sv
// rtl/rf_wb_sched.sv - register-file write-port scheduler and busy-bit scoreboard
// Round-robin shares one regfile write port among NUM_WB writeback sources and tracks RAW/WAW hazards.

module rf_wb_rr_arb #(
    parameter int N  = 3,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] last,
    input  logic          enable,
    output logic [N-1:0]  grant,
    output logic          found,
    output logic [PW-1:0] winner
);
    int            cand_i;
    logic [PW-1:0] cand;

    // Search begins one past the last winner, wrapping modulo N (N need not be a power of two).
    always_comb begin
        grant  = '0;
        found  = 1'b0;
        winner = last;
        cand_i = 0;
        cand   = '0;
        for (int k = 1; k <= N; k++) begin
            cand_i = int'(last) + k;
            if (cand_i >= N) begin
                cand_i = cand_i - N;
            end
            cand = PW'(cand_i);
            if (enable && !found && req[cand]) begin
                found       = 1'b1;
                winner      = cand;
                grant[cand] = 1'b1;
            end
        end
    end
endmodule

module rf_wb_sched #(
    parameter int NUM_WB = 3,
    parameter int AW     = 5,
    parameter int DW     = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 iss_valid,
    input  logic [AW-1:0]        iss_rd,
    output logic                 iss_ready,
    input  logic [AW-1:0]        chk_raddr1,
    input  logic [AW-1:0]        chk_raddr2,
    output logic                 chk_busy1,
    output logic                 chk_busy2,
    input  logic [NUM_WB-1:0]    wb_valid,
    input  logic [NUM_WB*AW-1:0] wb_waddr,
    input  logic [NUM_WB*DW-1:0] wb_wdata,
    output logic [NUM_WB-1:0]    wb_ready,
    output logic                 rf_we,
    output logic [AW-1:0]        rf_waddr,
    output logic [DW-1:0]        rf_wdata
);
    localparam int PW   = (NUM_WB > 1) ? $clog2(NUM_WB) : 1;
    localparam int NREG = 1 << AW;

    logic [NREG-1:0] busy;
    logic [PW-1:0]   rr_ptr;
    logic [NUM_WB-1:0] grant;
    logic            any_grant;
    logic [PW-1:0]   winner;
    logic            alloc;
    logic            wb_clear;

    rf_wb_rr_arb #(
        .N  (NUM_WB),
        .PW (PW)
    ) u_arb (
        .req    (wb_valid),
        .last   (rr_ptr),
        .enable (!reset && !flush),
        .grant  (grant),
        .found  (any_grant),
        .winner (winner)
    );

    assign wb_ready = grant;

    // Granted fields are steered to the regfile; r0 completes the handshake but never writes.
    always_comb begin
        rf_waddr = '0;
        rf_wdata = '0;
        for (int i = 0; i < NUM_WB; i++) begin
            if (grant[i]) begin
                rf_waddr = wb_waddr[i*AW +: AW];
                rf_wdata = wb_wdata[i*DW +: DW];
            end
        end
    end

    assign rf_we     = any_grant && (rf_waddr != '0);
    assign wb_clear  = rf_we;
    assign iss_ready = !reset && !flush && ((iss_rd == '0) || !busy[iss_rd]);
    assign alloc     = iss_valid && iss_ready && (iss_rd != '0);

    // A write landing this cycle is forwarded by the regfile, so it does not count as a hazard.
    assign chk_busy1 = !reset && (chk_raddr1 != '0) && busy[chk_raddr1]
                       && !(rf_we && (rf_waddr == chk_raddr1));
    assign chk_busy2 = !reset && (chk_raddr2 != '0) && busy[chk_raddr2]
                       && !(rf_we && (rf_waddr == chk_raddr2));

    always_ff @(posedge clk) begin
        if (reset) begin
            busy   <= '0;
            rr_ptr <= PW'(NUM_WB - 1);
        end else if (flush) begin
            busy <= '0;
        end else begin
            if (alloc) begin
                busy[iss_rd] <= 1'b1;
            end
            if (wb_clear) begin
                busy[rf_waddr] <= 1'b0;
            end
            if (any_grant) begin
                rr_ptr <= winner;
            end
        end
    end
endmodule

// File: tb/tb_rf_wb_sched.sv
// tb/tb_rf_wb_sched.sv - directed self-checking bench for rf_wb_sched
// Inputs change 1ns after posedge; outputs are sampled on the following negedge.

module tb_rf_wb_sched;
    localparam int NUM_WB = 3;
    localparam int AW     = 5;
    localparam int DW     = 32;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 flush;
    logic                 iss_valid;
    logic [AW-1:0]        iss_rd;
    logic                 iss_ready;
    logic [AW-1:0]        chk_raddr1;
    logic [AW-1:0]        chk_raddr2;
    logic                 chk_busy1;
    logic                 chk_busy2;
    logic [NUM_WB-1:0]    wb_valid;
    logic [NUM_WB*AW-1:0] wb_waddr;
    logic [NUM_WB*DW-1:0] wb_wdata;
    logic [NUM_WB-1:0]    wb_ready;
    logic                 rf_we;
    logic [AW-1:0]        rf_waddr;
    logic [DW-1:0]        rf_wdata;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    rf_wb_sched #(
        .NUM_WB (NUM_WB),
        .AW     (AW),
        .DW     (DW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .iss_valid  (iss_valid),
        .iss_rd     (iss_rd),
        .iss_ready  (iss_ready),
        .chk_raddr1 (chk_raddr1),
        .chk_raddr2 (chk_raddr2),
        .chk_busy1  (chk_busy1),
        .chk_busy2  (chk_busy2),
        .wb_valid   (wb_valid),
        .wb_waddr   (wb_waddr),
        .wb_wdata   (wb_wdata),
        .wb_ready   (wb_ready),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic set_src(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        wb_waddr[i*AW +: AW] = a;
        wb_wdata[i*DW +: DW] = d;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; iss_valid = 1'b0; iss_rd = '0;
        chk_raddr1 = '0; chk_raddr2 = '0;
        wb_valid = '0; wb_waddr = '0; wb_wdata = '0;

        // 1. reset outputs, allocate r5, then RAW and WAW on r5
        iss_valid = 1'b1; iss_rd = 5'd5; chk_raddr1 = 5'd5;
        sample();
        check("rst_iss_ready", 32'(iss_ready), 32'd0);
        check("rst_chk_busy1", 32'(chk_busy1), 32'd0);
        check("rst_wb_ready", 32'(wb_ready), 32'd0);
        check("rst_rf_we", 32'(rf_we), 32'd0);
        next_cycle();
        reset = 1'b0;
        sample();
        check("t1_alloc_ready", 32'(iss_ready), 32'd1);
        check("t1_busy_before", 32'(chk_busy1), 32'd0);
        next_cycle();
        sample();
        check("t1_raw_busy1", 32'(chk_busy1), 32'd1);
        check("t1_waw_stall", 32'(iss_ready), 32'd0);
        next_cycle();
        iss_valid = 1'b0;

        // 2. round robin with all sources requesting
        set_src(0, 5'd1, 32'h1111_0000);
        set_src(1, 5'd2, 32'h2222_0000);
        set_src(2, 5'd3, 32'h3333_0000);
        wb_valid = 3'b111;
        sample();
        check("t2_grant0", 32'(wb_ready), 32'b001);
        check("t2_waddr0", 32'(rf_waddr), 32'd1);
        check("t2_wdata0", 32'(rf_wdata), 32'h1111_0000);
        next_cycle();
        sample();
        check("t2_grant1", 32'(wb_ready), 32'b010);
        check("t2_wdata1", 32'(rf_wdata), 32'h2222_0000);
        next_cycle();
        sample();
        check("t2_grant2", 32'(wb_ready), 32'b100);
        check("t2_waddr2", 32'(rf_waddr), 32'd3);
        next_cycle();
        sample();
        check("t2_grant3", 32'(wb_ready), 32'b001);
        next_cycle();
        wb_valid = '0;

        // 3. busy r7, forwarded write by source 1 clears it
        iss_valid = 1'b1; iss_rd = 5'd7;
        sample();
        check("t3_alloc7", 32'(iss_ready), 32'd1);
        next_cycle();
        iss_valid = 1'b0; chk_raddr2 = 5'd7;
        sample();
        check("t3_busy7", 32'(chk_busy2), 32'd1);
        next_cycle();
        set_src(1, 5'd7, 32'hDEAD_BEEF);
        wb_valid = 3'b010;
        sample();
        check("t3_grant", 32'(wb_ready), 32'b010);
        check("t3_rf_we", 32'(rf_we), 32'd1);
        check("t3_rf_waddr", 32'(rf_waddr), 32'd7);
        check("t3_rf_wdata", 32'(rf_wdata), 32'hDEAD_BEEF);
        check("t3_fwd_busy2", 32'(chk_busy2), 32'd0);
        next_cycle();
        wb_valid = '0; iss_rd = 5'd7;
        sample();
        check("t3_cleared7", 32'(chk_busy2), 32'd0);
        check("t3_realloc7", 32'(iss_ready), 32'd1);
        next_cycle();

        // 4. r0 write is granted but never reaches the regfile
        set_src(0, 5'd0, 32'h0000_1234);
        wb_valid = 3'b001; iss_rd = 5'd0; chk_raddr1 = 5'd0;
        sample();
        check("t4_grant0", 32'(wb_ready), 32'b001);
        check("t4_rf_we", 32'(rf_we), 32'd0);
        check("t4_rf_wdata", 32'(rf_wdata), 32'h0000_1234);
        check("t4_iss_r0", 32'(iss_ready), 32'd1);
        check("t4_chk_r0", 32'(chk_busy1), 32'd0);
        next_cycle();
        wb_valid = '0;

        // 5. flush blocks grant/allocation and clears r3, r9, r5
        iss_valid = 1'b1; iss_rd = 5'd3;
        next_cycle();
        iss_rd = 5'd9;
        next_cycle();
        iss_rd = 5'd12; chk_raddr1 = 5'd3; chk_raddr2 = 5'd9;
        flush = 1'b1;
        set_src(1, 5'd3, 32'h5555_5555);
        wb_valid = 3'b010;
        sample();
        check("t5_flush_ready", 32'(wb_ready), 32'd0);
        check("t5_flush_we", 32'(rf_we), 32'd0);
        check("t5_flush_iss", 32'(iss_ready), 32'd0);
        check("t5_busy3_pre", 32'(chk_busy1), 32'd1);
        check("t5_busy9_pre", 32'(chk_busy2), 32'd1);
        next_cycle();
        flush = 1'b0; wb_valid = '0; iss_valid = 1'b0;
        chk_raddr1 = 5'd12;
        sample();
        check("t5_busy12_none", 32'(chk_busy1), 32'd0);
        check("t5_busy9_post", 32'(chk_busy2), 32'd0);
        chk_raddr1 = 5'd5; chk_raddr2 = 5'd3;
        sample();
        check("t5_busy5_post", 32'(chk_busy1), 32'd0);
        check("t5_busy3_post", 32'(chk_busy2), 32'd0);
        next_cycle();

        // 6. reset mid-operation restores pointer and busy bits
        iss_valid = 1'b1; iss_rd = 5'd4;
        next_cycle();
        iss_valid = 1'b0; chk_raddr1 = 5'd4;
        reset = 1'b1;
        set_src(0, 5'd10, 32'hA0A0_A0A0);
        set_src(2, 5'd11, 32'hC2C2_C2C2);
        wb_valid = 3'b101;
        sample();
        check("t6_rst_ready", 32'(wb_ready), 32'd0);
        check("t6_rst_we", 32'(rf_we), 32'd0);
        next_cycle();
        reset = 1'b0;
        sample();
        check("t6_first_grant", 32'(wb_ready), 32'b001);
        check("t6_busy4_clr", 32'(chk_busy1), 32'd0);
        next_cycle();
        sample();
        check("t6_second_grant", 32'(wb_ready), 32'b100);
        check("t6_waddr", 32'(rf_waddr), 32'd11);
        next_cycle();
        wb_valid = '0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
